// File: rtl/painterengine_gpu_dma_reader_arbiter.sv
// Round-robin arbiter that time-shares one single-shot GPU DMA reader between four requesters.
// Each job pulses the reader reset, routes the winner to it, waits for done/error/watchdog, then acks.
module painterengine_gpu_dma_reader_arbiter #(
    parameter int RESET_CYCLES  = 2,
    parameter int WATCHDOG_BITS = 20
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_reset,
    input  logic [3:0]   i_wire_req,
    input  logic [127:0] i_wire_req_address,
    input  logic [127:0] i_wire_req_length,
    input  logic [3:0]   i_wire_req_data_next,
    output logic [3:0]   o_wire_grant,
    output logic         o_wire_busy,
    output logic [3:0]   o_wire_ack,
    output logic [3:0]   o_wire_ack_error,
    output logic [2:0]   o_wire_ack_error_type,
    output logic         o_wire_reader_resetn,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    output logic [3:0]   o_wire_reader_router,
    output logic [3:0]   o_wire_reader_data_next,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error,
    input  logic [2:0]   i_wire_reader_error_type
);

    localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RESET_CYCLES - 1);
    localparam logic [2:0] WATCHDOG_ERR_TYPE = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RSTHOLD,
        ST_RUN,
        ST_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               grant_q, grant_d;
    logic [1:0]               idx_q, idx_d;
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              len_q, len_d;
    logic [RST_CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [WATCHDOG_BITS-1:0] wd_cnt_q, wd_cnt_d;
    logic [3:0]               ack_q, ack_d;
    logic [3:0]               ack_error_q, ack_error_d;
    logic [2:0]               err_type_q, err_type_d;
    logic                     busy_q, busy_d;
    logic                     resetn_q, resetn_d;
    logic [3:0]               router_q, router_d;

    logic                     win_found;
    logic [1:0]               win_idx;
    logic [1:0]               cand;
    logic [WATCHDOG_BITS-1:0] wd_inc;

    assign wd_inc = wd_cnt_q + WATCHDOG_BITS'(1);

    // rr_ptr_q holds the first channel to search, i.e. one past the last acked channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found && i_wire_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rst_cnt_d   = rst_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        ack_d       = 4'b0000;
        ack_error_d = 4'b0000;
        err_type_d  = 3'b000;

        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (win_found) begin
                    grant_d   = 4'b0001 << win_idx;
                    idx_d     = win_idx;
                    addr_d    = i_wire_req_address[{win_idx, 5'b00000} +: 32];
                    len_d     = i_wire_req_length[{win_idx, 5'b00000} +: 32];
                    rst_cnt_d = RST_LOAD;
                    state_d   = ST_RSTHOLD;
                end
            end
            ST_RSTHOLD: begin
                if (rst_cnt_q == '0) begin
                    wd_cnt_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
                end
            end
            ST_RUN: begin
                wd_cnt_d = wd_inc;
                // Error outranks done; the watchdog only fires if the reader said nothing.
                if (i_wire_reader_error) begin
                    ack_d       = grant_q;
                    ack_error_d = grant_q;
                    err_type_d  = i_wire_reader_error_type;
                    state_d     = ST_ACK;
                end else if (i_wire_reader_done) begin
                    ack_d   = grant_q;
                    state_d = ST_ACK;
                end else if (wd_inc[WATCHDOG_BITS-1]) begin
                    ack_d       = grant_q;
                    ack_error_d = grant_q;
                    err_type_d  = WATCHDOG_ERR_TYPE;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                rr_ptr_d = idx_q + 2'd1;
                grant_d  = 4'b0000;
                state_d  = ST_IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        resetn_d = (state_d == ST_RUN);
        router_d = (state_d == ST_RUN) ? grant_d : 4'b0000;
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            rst_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            ack_q       <= '0;
            ack_error_q <= '0;
            err_type_q  <= '0;
            busy_q      <= 1'b0;
            resetn_q    <= 1'b0;
            router_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rst_cnt_q   <= rst_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            ack_q       <= ack_d;
            ack_error_q <= ack_error_d;
            err_type_q  <= err_type_d;
            busy_q      <= busy_d;
            resetn_q    <= resetn_d;
            router_q    <= router_d;
        end
    end

    always_comb begin
        o_wire_reader_address = '0;
        o_wire_reader_length  = '0;
        for (int n = 0; n < 4; n++) begin
            o_wire_reader_address[n*32 +: 32] = grant_q[n] ? addr_q : 32'h0;
            o_wire_reader_length[n*32 +: 32]  = grant_q[n] ? len_q  : 32'h0;
        end
    end

    assign o_wire_grant            = grant_q;
    assign o_wire_busy             = busy_q;
    assign o_wire_ack              = ack_q;
    assign o_wire_ack_error        = ack_error_q;
    assign o_wire_ack_error_type   = err_type_q;
    assign o_wire_reader_resetn    = resetn_q;
    assign o_wire_reader_router    = router_q;
    assign o_wire_reader_data_next = i_wire_req_data_next & router_q;

endmodule
